// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state encoding and register constants for the pipeline hazard sequencer.
package pipeline_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an IF_ID reader of the load destination in ID_EX.
// Purely combinational, zero latency, no backpressure of its own.
module pipeline_hazard_ctrl_hazard_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  logic       i_idExMemRead,
   input  logic [4:0] i_idExRt,
   input  logic [4:0] i_ifIdRs,
   input  logic [4:0] i_ifIdRt,
   input  logic       i_ifIdUsesRt,
   output logic       o_loadUse
);

   // $zero never carries a real dependency, so a load into it cannot stall.
   assign o_loadUse = i_idExMemRead & (i_idExRt != REG_ZERO) &
                      ((i_idExRt == i_ifIdRs) | (i_ifIdUsesRt & (i_idExRt == i_ifIdRt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Mealy enables/flushes, zero latency.
// Data-memory backpressure via req/ready freezes every stage; a stuck access halts until reset.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 32
)(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_idExMemRead,
   input  logic [4:0]       i_idExRt,
   input  logic [4:0]       i_ifIdRs,
   input  logic [4:0]       i_ifIdRt,
   input  logic             i_ifIdUsesRt,
   input  logic             i_branchTaken,
   input  logic             i_exMemAccess,
   input  logic             i_dmemReady,
   output logic             o_dmemReq,
   output logic             o_pcWrite,
   output logic             o_ifIdWrite,
   output logic             o_idExWrite,
   output logic             o_exMemWrite,
   output logic             o_memWbWrite,
   output logic             o_ifIdFlush,
   output logic             o_idExFlush,
   output logic             o_exMemFlush,
   output logic             o_memTimeout,
   output logic [CNT_W-1:0] o_stallCount
);

   localparam logic [7:0] WAIT_MAX_C = WAIT_MAX[7:0];

   state_t           r_state;
   state_t           w_next_state;
   logic [7:0]       r_wait_cnt;
   logic [7:0]       w_next_wait_cnt;
   logic             r_mem_timeout;
   logic             w_timeout_set;
   logic [CNT_W-1:0] r_stall_cnt;
   logic             w_load_use;
   logic             w_advance;

   pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
      .i_idExMemRead (i_idExMemRead),
      .i_idExRt      (i_idExRt),
      .i_ifIdRs      (i_ifIdRs),
      .i_ifIdRt      (i_ifIdRt),
      .i_ifIdUsesRt  (i_ifIdUsesRt),
      .o_loadUse     (w_load_use)
   );

   assign w_advance = ((r_state == RUN) & (~i_exMemAccess | i_dmemReady)) |
                      ((r_state == MEM_WAIT) & i_dmemReady);

   always_comb begin
      w_next_state    = r_state;
      w_next_wait_cnt = r_wait_cnt;
      w_timeout_set   = 1'b0;
      o_dmemReq       = 1'b0;
      o_pcWrite       = 1'b0;
      o_ifIdWrite     = 1'b0;
      o_idExWrite     = 1'b0;
      o_exMemWrite    = 1'b0;
      o_memWbWrite    = 1'b0;
      o_ifIdFlush     = 1'b0;
      o_idExFlush     = 1'b0;
      o_exMemFlush    = 1'b0;
      if (!i_reset) begin
         case (r_state)
            RUN: begin
               o_dmemReq = i_exMemAccess;
               if (!w_advance) begin
                  w_next_state    = MEM_WAIT;
                  w_next_wait_cnt = 8'd1;
               end
            end
            MEM_WAIT: begin
               o_dmemReq = i_exMemAccess;
               if (i_dmemReady) begin
                  w_next_state    = RUN;
                  w_next_wait_cnt = 8'd0;
               end else if (r_wait_cnt == WAIT_MAX_C) begin
                  w_next_state  = HALT;
                  w_timeout_set = 1'b1;
               end else begin
                  w_next_wait_cnt = r_wait_cnt + 8'd1;
               end
            end
            default: ;
         endcase
         // A taken branch squashes the younger load-use pair, so it wins.
         if (w_advance) begin
            o_idExWrite  = 1'b1;
            o_exMemWrite = 1'b1;
            o_memWbWrite = 1'b1;
            if (i_branchTaken) begin
               o_pcWrite    = 1'b1;
               o_ifIdWrite  = 1'b1;
               o_ifIdFlush  = 1'b1;
               o_idExFlush  = 1'b1;
               o_exMemFlush = 1'b1;
            end else if (w_load_use) begin
               o_idExFlush = 1'b1;
            end else begin
               o_pcWrite   = 1'b1;
               o_ifIdWrite = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= RUN;
         r_wait_cnt    <= 8'd0;
         r_mem_timeout <= 1'b0;
         r_stall_cnt   <= '0;
      end else begin
         r_state    <= w_next_state;
         r_wait_cnt <= w_next_wait_cnt;
         if (w_timeout_set) begin
            r_mem_timeout <= 1'b1;
         end
         if (!o_pcWrite && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

   assign o_memTimeout = r_mem_timeout;
   assign o_stallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

   localparam int WAIT_MAX = 4;
   localparam int CNT_W    = 5;
   localparam int SAT      = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             idExMemRead;
   logic [4:0]       idExRt, ifIdRs, ifIdRt;
   logic             ifIdUsesRt, branchTaken, exMemAccess, dmemReady;
   logic             dmemReq, pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite;
   logic             ifIdFlush, idExFlush, exMemFlush, memTimeout;
   logic [CNT_W-1:0] stallCount;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Model state: plain flags and integers describing where the pipeline is.
   bit m_waiting = 1'b0;
   bit m_halted  = 1'b0;
   bit m_timeout = 1'b0;
   int m_wait    = 0;
   int m_stall   = 0;

   pipeline_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_reset(reset),
      .i_idExMemRead(idExMemRead), .i_idExRt(idExRt), .i_ifIdRs(ifIdRs),
      .i_ifIdRt(ifIdRt), .i_ifIdUsesRt(ifIdUsesRt), .i_branchTaken(branchTaken),
      .i_exMemAccess(exMemAccess), .i_dmemReady(dmemReady),
      .o_dmemReq(dmemReq), .o_pcWrite(pcWrite), .o_ifIdWrite(ifIdWrite),
      .o_idExWrite(idExWrite), .o_exMemWrite(exMemWrite), .o_memWbWrite(memWbWrite),
      .o_ifIdFlush(ifIdFlush), .o_idExFlush(idExFlush), .o_exMemFlush(exMemFlush),
      .o_memTimeout(memTimeout), .o_stallCount(stallCount)
   );

   always #5 clk = ~clk;

   // {dmemReq, pc, ifId, idEx, exMem, memWb, ifIdFlush, idExFlush, exMemFlush}
   function automatic logic [8:0] exp_vec();
      bit lu, go;
      if (reset || m_halted) return 9'b0;
      lu = idExMemRead && (idExRt != 0) &&
           ((idExRt == ifIdRs) || (ifIdUsesRt && (idExRt == ifIdRt)));
      go = m_waiting ? dmemReady : (!exMemAccess || dmemReady);
      if (!go)         return {exMemAccess, 8'b0};
      if (branchTaken) return {exMemAccess, 8'b11111_111};
      if (lu)          return {exMemAccess, 8'b00111_010};
      return {exMemAccess, 8'b11111_000};
   endfunction

   function automatic logic [8:0] got_vec();
      return {dmemReq, pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite,
              ifIdFlush, idExFlush, exMemFlush};
   endfunction

   always @(posedge clk) begin
      logic [8:0] e;
      e = exp_vec();
      if (reset) begin
         m_waiting = 0; m_halted = 0; m_timeout = 0; m_wait = 0; m_stall = 0;
      end else begin
         if (!e[7] && m_stall < SAT) m_stall++;
         if (m_halted) begin
         end else if (m_waiting) begin
            if (dmemReady) begin
               m_waiting = 0; m_wait = 0;
            end else if (m_wait == WAIT_MAX) begin
               m_halted = 1; m_timeout = 1;
            end else begin
               m_wait++;
            end
         end else if (exMemAccess && !dmemReady) begin
            m_waiting = 1; m_wait = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [8:0] e;
         e = exp_vec();
         checks++;
         if (got_vec() !== e) begin
            errors++;
            $display("FAIL model_outputs t=%0t got=%b expected=%b", $time, got_vec(), e);
         end
         checks++;
         if (int'(stallCount) != m_stall) begin
            errors++;
            $display("FAIL model_stallCount t=%0t got=%0d expected=%0d", $time, stallCount, m_stall);
         end
         checks++;
         if (memTimeout !== m_timeout) begin
            errors++;
            $display("FAIL model_memTimeout t=%0t got=%b expected=%b", $time, memTimeout, m_timeout);
         end
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      idExMemRead = 0; idExRt = 0; ifIdRs = 0; ifIdRt = 0; ifIdUsesRt = 0;
      branchTaken = 0; exMemAccess = 0; dmemReady = 0;
   endtask

   initial begin
      reset = 1;
      idle();
      tick();
      chk_en = 1;
      tick();
      #2;
      chk("reset_outputs", int'(got_vec()), 0);
      chk("reset_stall", int'(stallCount), 0);
      chk("reset_timeout", int'(memTimeout), 0);
      reset = 0;
      tick();

      // Load-use stall and its two non-stalling variants.
      idExMemRead = 1; idExRt = 8; ifIdRs = 8;
      #2;
      chk("lu_vec", int'(got_vec()), 9'b0_00111_010);
      chk("lu_stall_before", int'(stallCount), 0);
      tick();
      chk("lu_stall_after", int'(stallCount), 1);
      ifIdRs = 9; ifIdRt = 8; ifIdUsesRt = 0;
      #2;
      chk("lu_rt_unused_pc", int'(pcWrite), 1);
      ifIdRs = 0; idExRt = 0;
      #2;
      chk("lu_zero_reg_pc", int'(pcWrite), 1);
      tick();

      // Branch overrides a simultaneous load-use.
      idExRt = 8; ifIdRs = 8; branchTaken = 1;
      #2;
      chk("br_lu_vec", int'(got_vec()), 9'b0_11111_111);
      tick();
      chk("br_lu_stall", int'(stallCount), 1);
      idle();

      // Three-cycle memory wait.
      exMemAccess = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("wait_vec", int'(got_vec()), 9'b1_00000_000);
         tick();
      end
      dmemReady = 1;
      #2;
      chk("wait_ready_vec", int'(got_vec()), 9'b1_11111_000);
      tick();
      chk("wait_stall", int'(stallCount), 4);

      // Same wait with a branch held in EX_MEM.
      dmemReady = 0; branchTaken = 1;
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("wait_br_vec", int'(got_vec()), 9'b1_00000_000);
         tick();
      end
      dmemReady = 1;
      #2;
      chk("wait_br_ready_vec", int'(got_vec()), 9'b1_11111_111);
      tick();
      chk("wait_br_stall", int'(stallCount), 7);

      // Zero-wait access keeps the FSM in RUN.
      branchTaken = 0; exMemAccess = 1; dmemReady = 1;
      #2;
      chk("zero_wait_pc", int'(pcWrite), 1);
      tick();
      exMemAccess = 0; dmemReady = 0;
      #2;
      chk("zero_wait_run_pc", int'(pcWrite), 1);
      chk("zero_wait_stall", int'(stallCount), 7);
      tick();

      // Timeout into HALT, then recovery by reset.
      exMemAccess = 1;
      for (int i = 0; i < 4; i++) tick();
      chk("timeout_not_yet", int'(memTimeout), 0);
      tick();
      chk("timeout_set", int'(memTimeout), 1);
      #2;
      chk("halt_vec", int'(got_vec()), 0);
      exMemAccess = 0;
      #2;
      chk("halt_idle_pc", int'(pcWrite), 0);
      tick();
      chk("halt_stall", int'(stallCount), 13);
      reset = 1;
      tick();
      reset = 0;
      #2;
      chk("post_reset_timeout", int'(memTimeout), 0);
      chk("post_reset_stall", int'(stallCount), 0);
      chk("post_reset_pc", int'(pcWrite), 1);
      tick();

      // Random traffic against the model.
      for (int n = 0; n < 4000; n++) begin
         reset       = ($urandom_range(0, 39) == 0);
         idExMemRead = ($urandom_range(0, 2) == 0);
         idExRt      = 5'($urandom_range(0, 3));
         ifIdRs      = 5'($urandom_range(0, 3));
         ifIdRt      = 5'($urandom_range(0, 3));
         ifIdUsesRt  = 1'($urandom_range(0, 1));
         branchTaken = ($urandom_range(0, 7) == 0);
         exMemAccess = ($urandom_range(0, 2) == 0);
         dmemReady   = 1'($urandom_range(0, 1));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
